// File: rtl/seg7_scan_decoder_if.sv
// Bus between a multiplexed 7-segment driver and the scan decoder that reads it back.
// seg7s is a level-sampled bus with no valid/ready handshake; the decoder qualifies it by stability. All outputs are registered. frame_done and scan_err are single-cycle pulses.
interface seg7_scan_decoder_if;
    logic [15:0] seg7s;
    logic [31:0] digits;
    logic [7:0]  dps;
    logic [7:0]  blank;
    logic [7:0]  glyph_err;
    logic        frame_done;
    logic        scan_err;

    modport master (
        output seg7s,
        input  digits, dps, blank, glyph_err, frame_done, scan_err
    );

    modport slave (
        input  seg7s,
        output digits, dps, blank, glyph_err, frame_done, scan_err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Rebuilds the eight hex digits shown by a multiplexed 7-segment driver.
// A slot is captured once, after it has been stable for SETTLE consecutive cycles.
module seg7_scan_decoder #(
    parameter int SETTLE = 4,
    parameter int CW     = 8
) (
    input logic                 clk,
    input logic                 reset,
    seg7_scan_decoder_if.slave  bus
);
    logic [15:0]   r_s_q;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_seen;
    logic [31:0]   r_digits;
    logic [7:0]    r_dps;
    logic [7:0]    r_blank;
    logic [7:0]    r_glyph_err;
    logic          r_frame_done;
    logic          r_scan_err;

    logic [6:0] w_segs;
    logic [7:0] w_an_low;
    logic [3:0] w_hex;
    logic       w_legal;
    logic       w_blank;
    logic [2:0] w_idx;
    logic       w_one_hot;
    logic       w_multi;
    logic       w_stable;
    logic       w_capture;
    logic [7:0] w_seen_next;

    assign w_segs   = ~r_s_q[15:9];
    assign w_an_low = ~r_s_q[7:0];
    assign w_blank  = (w_segs == 7'b0000000);

    always_comb begin
        w_hex   = 4'h0;
        w_legal = 1'b1;
        case (w_segs)
            7'b1111110: w_hex = 4'h0;
            7'b0110000: w_hex = 4'h1;
            7'b1101101: w_hex = 4'h2;
            7'b1111001: w_hex = 4'h3;
            7'b0110011: w_hex = 4'h4;
            7'b1011011: w_hex = 4'h5;
            7'b1011111: w_hex = 4'h6;
            7'b1110000: w_hex = 4'h7;
            7'b1111111: w_hex = 4'h8;
            7'b1111011: w_hex = 4'h9;
            7'b1110111: w_hex = 4'hA;
            7'b0011111: w_hex = 4'hB;
            7'b1001110: w_hex = 4'hC;
            7'b0111101: w_hex = 4'hD;
            7'b1001111: w_hex = 4'hE;
            7'b1000111: w_hex = 4'hF;
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_an_low[i]) w_idx = 3'(i);
        end
    end

    assign w_one_hot   = (w_an_low != 8'h00) && ((w_an_low & (w_an_low - 8'd1)) == 8'h00);
    assign w_multi     = (w_an_low != 8'h00) && !w_one_hot;
    assign w_stable    = (bus.seg7s == r_s_q);
    // The capture edge is the one that moves the counter onto SETTLE; it then holds there.
    assign w_capture   = w_stable && (r_cnt == CW'(SETTLE - 1));
    assign w_seen_next = r_seen | w_an_low;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_q        <= '0;
            r_cnt        <= '0;
            r_seen       <= '0;
            r_digits     <= '0;
            r_dps        <= '0;
            r_blank      <= '0;
            r_glyph_err  <= '0;
            r_frame_done <= 1'b0;
            r_scan_err   <= 1'b0;
        end else begin
            r_s_q        <= bus.seg7s;
            r_frame_done <= 1'b0;
            r_scan_err   <= 1'b0;
            if (!w_stable) begin
                r_cnt <= '0;
            end else if (r_cnt < CW'(SETTLE)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture && w_one_hot) begin
                r_digits[{w_idx, 2'b00} +: 4] <= (w_legal && !w_blank) ? w_hex : 4'h0;
                r_dps[w_idx]       <= ~r_s_q[8];
                r_blank[w_idx]     <= w_blank;
                r_glyph_err[w_idx] <= !w_legal && !w_blank;
                if (w_seen_next == 8'hFF) begin
                    r_frame_done <= 1'b1;
                    r_seen       <= '0;
                end else begin
                    r_seen <= w_seen_next;
                end
            end else if (w_capture && w_multi) begin
                r_scan_err <= 1'b1;
            end
        end
    end

    assign bus.digits     = r_digits;
    assign bus.dps        = r_dps;
    assign bus.blank      = r_blank;
    assign bus.glyph_err  = r_glyph_err;
    assign bus.frame_done = r_frame_done;
    assign bus.scan_err   = r_scan_err;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives scan slots and checks the rebuilt digits and flags.
module tb_seg7_scan_decoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_decoder_if bus();

    seg7_scan_decoder #(.SETTLE(4), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;
    int se_cnt   = 0;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.scan_err === 1'b1) se_cnt++;
    end

    function automatic logic [6:0] glyph(input int h);
        case (h)
            0:  glyph = 7'b1111110;
            1:  glyph = 7'b0110000;
            2:  glyph = 7'b1101101;
            3:  glyph = 7'b1111001;
            4:  glyph = 7'b0110011;
            5:  glyph = 7'b1011011;
            6:  glyph = 7'b1011111;
            7:  glyph = 7'b1110000;
            8:  glyph = 7'b1111111;
            9:  glyph = 7'b1111011;
            10: glyph = 7'b1110111;
            11: glyph = 7'b0011111;
            12: glyph = 7'b1001110;
            13: glyph = 7'b0111101;
            14: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    function automatic logic [15:0] word(input logic [6:0] g, input logic dp_lit, input int k);
        logic [7:0] an;
        an = 8'b1 << k;
        word = {~g, ~dp_lit, ~an};
    endfunction

    task automatic slot(input logic [15:0] w, input int n);
        bus.seg7s = w;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.seg7s = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.seg7s = 16'h0000;
        #1;
        checks++; if (bus.digits !== 32'h0) begin failures++; $display("FAIL reset_digits got=%h exp=%h", bus.digits, 32'h0); end
        checks++; if (bus.dps !== 8'h0) begin failures++; $display("FAIL reset_dps got=%h exp=00", bus.dps); end
        checks++; if (bus.blank !== 8'h0) begin failures++; $display("FAIL reset_blank got=%h exp=00", bus.blank); end
        checks++; if (bus.glyph_err !== 8'h0) begin failures++; $display("FAIL reset_glyph_err got=%h exp=00", bus.glyph_err); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        checks++; if (bus.scan_err !== 1'b0) begin failures++; $display("FAIL reset_scan_err got=%b exp=0", bus.scan_err); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_settle();
        slot({8'b0000_0011, 8'b1111_1110}, 5);
        checks++; if (bus.digits[3:0] !== 4'h0) begin failures++; $display("FAIL settle_zero_digit got=%h exp=0", bus.digits[3:0]); end
        checks++; if (bus.dps[0] !== 1'b0) begin failures++; $display("FAIL settle_zero_dp got=%b exp=0", bus.dps[0]); end
        checks++; if (bus.blank !== 8'h0) begin failures++; $display("FAIL settle_zero_blank got=%h exp=00", bus.blank); end
        slot(word(glyph(7), 1'b0, 0), 4);
        checks++; if (bus.digits !== 32'h0) begin failures++; $display("FAIL settle_short_hold got=%h exp=%h", bus.digits, 32'h0); end
        slot(word(glyph(7), 1'b0, 0), 1);
        checks++; if (bus.digits !== 32'h7) begin failures++; $display("FAIL settle_latency got=%h exp=%h", bus.digits, 32'h7); end
    endtask

    task automatic test_scan();
        int fd0;
        apply_reset();
        fd0 = fd_cnt;
        for (int k = 0; k < 7; k++) slot(word(glyph(k + 1), 1'b0, k), 10);
        bus.seg7s = word(glyph(8), 1'b1, 7);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (e >= 4 && e <= 6) begin
                checks++;
                if (bus.frame_done !== (e == 5)) begin
                    failures++;
                    $display("FAIL scan_frame_done_edge%0d got=%b exp=%b", e, bus.frame_done, (e == 5));
                end
            end
        end
        checks++; if (bus.digits !== 32'h8765_4321) begin failures++; $display("FAIL scan_digits got=%h exp=87654321", bus.digits); end
        checks++; if (bus.dps !== 8'h80) begin failures++; $display("FAIL scan_dps got=%h exp=80", bus.dps); end
        checks++; if (bus.blank !== 8'h00 || bus.glyph_err !== 8'h00) begin failures++; $display("FAIL scan_flags got=%h/%h exp=00/00", bus.blank, bus.glyph_err); end
        checks++; if (fd_cnt - fd0 !== 1) begin failures++; $display("FAIL scan_frame_count got=%0d exp=1", fd_cnt - fd0); end
    endtask

    task automatic test_scan_err();
        int fd0, se0;
        fd0 = fd_cnt;
        se0 = se_cnt;
        slot({~glyph(9), 1'b1, 8'b1111_0011}, 10);
        checks++; if (se_cnt - se0 !== 1) begin failures++; $display("FAIL scan_err_pulses got=%0d exp=1", se_cnt - se0); end
        checks++; if (bus.digits !== 32'h8765_4321) begin failures++; $display("FAIL scan_err_digits got=%h exp=87654321", bus.digits); end
        checks++; if (bus.dps !== 8'h80) begin failures++; $display("FAIL scan_err_dps got=%h exp=80", bus.dps); end
        checks++; if (fd_cnt !== fd0) begin failures++; $display("FAIL scan_err_frame got=%0d exp=%0d", fd_cnt, fd0); end
    endtask

    task automatic test_flags();
        int fd0;
        fd0 = fd_cnt;
        slot({7'b1111111, 1'b1, 8'b1111_1011}, 10);
        slot({~7'b1010101, 1'b1, 8'b1111_0111}, 10);
        checks++; if (bus.blank !== 8'h04) begin failures++; $display("FAIL flags_blank got=%h exp=04", bus.blank); end
        checks++; if (bus.glyph_err !== 8'h08) begin failures++; $display("FAIL flags_glyph_err got=%h exp=08", bus.glyph_err); end
        checks++; if (bus.digits !== 32'h8765_0021) begin failures++; $display("FAIL flags_digits got=%h exp=87650021", bus.digits); end
        slot(word(glyph(10), 1'b1, 0), 10);
        slot(word(glyph(11), 1'b0, 1), 10);
        slot(word(glyph(12), 1'b0, 4), 10);
        slot(word(glyph(13), 1'b0, 5), 10);
        slot(word(glyph(14), 1'b0, 6), 10);
        checks++; if (fd_cnt !== fd0) begin failures++; $display("FAIL flags_early_frame got=%0d exp=%0d", fd_cnt, fd0); end
        slot(word(glyph(15), 1'b0, 7), 10);
        checks++; if (fd_cnt !== fd0 + 1) begin failures++; $display("FAIL flags_frame got=%0d exp=%0d", fd_cnt, fd0 + 1); end
        checks++; if (bus.digits !== 32'hFEDC_00BA) begin failures++; $display("FAIL flags_frame_digits got=%h exp=FEDC00BA", bus.digits); end
        checks++; if (bus.dps !== 8'h01) begin failures++; $display("FAIL flags_frame_dps got=%h exp=01", bus.dps); end
    endtask

    task automatic test_reset_mid();
        int fd0;
        int order[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
        fd0 = fd_cnt;
        for (int k = 0; k < 5; k++) slot(word(glyph(9), 1'b0, k), 10);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.digits !== 32'h0) begin failures++; $display("FAIL midreset_digits got=%h exp=0", bus.digits); end
        checks++; if (bus.dps !== 8'h0 || bus.blank !== 8'h0 || bus.glyph_err !== 8'h0) begin failures++; $display("FAIL midreset_flags got=%h/%h/%h exp=00/00/00", bus.dps, bus.blank, bus.glyph_err); end
        checks++; if (bus.frame_done !== 1'b0 || bus.scan_err !== 1'b0) begin failures++; $display("FAIL midreset_pulses got=%b/%b exp=0/0", bus.frame_done, bus.scan_err); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            slot(word(glyph(order[i]), 1'b0, order[i]), 10);
            if (i == 2 || i == 6) begin
                checks++;
                if (fd_cnt !== fd0) begin failures++; $display("FAIL midreset_early_frame_slot%0d got=%0d exp=%0d", i, fd_cnt, fd0); end
            end
        end
        checks++; if (fd_cnt !== fd0 + 1) begin failures++; $display("FAIL midreset_frame got=%0d exp=%0d", fd_cnt, fd0 + 1); end
        checks++; if (bus.digits !== 32'h7654_3210) begin failures++; $display("FAIL midreset_digits_after got=%h exp=76543210", bus.digits); end
    endtask

    task automatic test_glitch();
        int fd0;
        apply_reset();
        for (int k = 0; k < 7; k++) slot(word(glyph(1), 1'b0, k), 10);
        fd0 = fd_cnt;
        slot(word(glyph(7), 1'b0, 7), 7);
        checks++; if (fd_cnt !== fd0 + 1) begin failures++; $display("FAIL glitch_first_half got=%0d exp=%0d", fd_cnt, fd0 + 1); end
        slot(word(glyph(14), 1'b0, 0), 1);
        slot(word(glyph(7), 1'b0, 7), 7);
        checks++; if (bus.digits !== 32'h7111_1111) begin failures++; $display("FAIL glitch_no_capture got=%h exp=71111111", bus.digits); end
        checks++; if (fd_cnt !== fd0 + 1) begin failures++; $display("FAIL glitch_second_half_frame got=%0d exp=%0d", fd_cnt, fd0 + 1); end
        for (int k = 0; k < 6; k++) slot(word(glyph(2), 1'b0, k), 10);
        checks++; if (fd_cnt !== fd0 + 1) begin failures++; $display("FAIL glitch_partial got=%0d exp=%0d", fd_cnt, fd0 + 1); end
        slot(word(glyph(2), 1'b0, 6), 10);
        checks++; if (fd_cnt !== fd0 + 2) begin failures++; $display("FAIL glitch_second_capture got=%0d exp=%0d", fd_cnt, fd0 + 2); end
        checks++; if (bus.digits !== 32'h7222_2222) begin failures++; $display("FAIL glitch_digits got=%h exp=72222222", bus.digits); end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_scan();
        test_scan_err();
        test_flags();
        test_reset_mid();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment driver. Samples the 16-bit {CA,CB,CC,CD,CE,CF,CG,DP,AN[7:0]} bus as the display block drives it.
- Waits for each scan slot to settle, then rebuilds the 8 displayed hex digits, decimal points and blank/illegal-glyph flags.
- Pulses once per complete scan frame.
- Sits beside the display block on the same clock. Used for on-chip readback of the shown time and as the bench's display monitor.

Parameters:
- SETTLE, 4, consecutive equal-sample cycles required before a slot is captured (legal range 1..255).
- CW, 8, width of the stability counter; must satisfy 2^CW > SETTLE.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-high reset.
- seg7s  input  16  [15]=CA … [9]=CG, [8]=DP, [7:0]=AN[7:0]. Segments and anodes are all active-low.
- digits  output  32  decoded hex value; digit k at [4k+3:4k].
- dps  output  8  decimal point lit, per digit (active-high).
- blank  output  8  digit captured with all segments off.
- glyph_err  output  8  digit captured with a pattern not in the decode table.
- frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the last pulse.
- scan_err  output  1  one-cycle pulse when a settled sample has more than one anode low.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0. Internal sample register s_q, counter cnt and seen[7:0] are also 0. Reset mid-frame discards partial progress.
- Every edge, s_q <= seg7s.
- Stability counter:
  - If seg7s != s_q: cnt <= 0.
  - Else if cnt < SETTLE: cnt <= cnt+1.
  - Otherwise cnt holds.
- Capture fires on the edge where cnt goes from SETTLE-1 to SETTLE. Fields are taken from s_q.
- Latency: a pattern that is stable from before edge 1 is captured at edge SETTLE+1 and is visible on the outputs after that edge. Any pattern held for fewer than SETTLE+1 edges is ignored. Only one capture occurs per stable period.
- Anode handling at capture:
  - Exactly one AN bit low (index k): update digit k (see below) and set seen[k]. Recapturing a digit already seen overwrites it; seen[k] stays 1.
  - All AN high: no update.
  - Two or more AN low: scan_err = 1 for that one cycle. No digit, dp, flag or seen update.
- Digit k update:
  - dps[k] <= ~DP.
  - Segments are inverted to active-high {a,b,c,d,e,f,g} = ~{CA..CG}, then decoded:
    - 0=1111110, 1=0110000, 2=1101101, 3=1111001
    - 4=0110011, 5=1011011, 6=1011111, 7=1110000
    - 8=1111111, 9=1111011, A=1110111, b=0011111
    - C=1001110, d=0111101, E=1001111, F=1000111
  - 0000000: digits[k]=0, blank[k]=1, glyph_err[k]=0.
  - Any other pattern: digits[k]=0, glyph_err[k]=1, blank[k]=0.
  - Legal glyph: blank[k]=0, glyph_err[k]=0.
- Frame completion:
  - When a capture makes seen == 8'hFF, frame_done = 1 on the cycle after that edge and seen is cleared in the same step.
  - Digit and flag outputs are never cleared by frame completion.
- Duplicate anode orders, any scan order, and skipped digits are all tolerated. frame_done simply waits until all 8 have been captured.
- Outputs are registered only; there are no combinational paths from seg7s.

Test Plan:
- Reset, then drive seg7s = {8'b0000_0011 (7-seg "0" = segs 0000001, DP off), AN=8'b1111_1110} for 5 cycles (SETTLE=4) → digits[3:0]=0, dps[0]=0, blank=0 after edge 5. Holding for only 4 cycles → no update.
- Scan all 8 digits, each held 10 cycles with glyphs 1,2,3,4,5,6,7,8, digit 7 with DP low → digits=32'h8765_4321, dps=8'h80. frame_done is a single pulse one cycle after digit 7's capture edge.
- Slot with AN=8'b1111_0011 for 10 cycles → exactly one scan_err pulse. Digits, flags and seen are unchanged, and no frame_done occurs.
- Segments all high (blank) on digit 2, and illegal pattern 1010101 on digit 3 → blank[2]=1, glyph_err[3]=1, digits nibbles 2 and 3 = 0.
- Assert reset in the middle of a frame after 5 digits, then scan 8 fresh digits → all outputs are 0 during reset, and frame_done fires only after all 8 new captures.
- Single-cycle glitch (different anode) inserted inside a held slot → that digit is captured exactly once in each stable half, and the glitch produces no capture.
